// File: rtl/ltc2992_cfg_seq_pkg.sv
// Shared types and constants for the LTC2992 configuration sequencer.
package ltc2992_cfg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_e;

  // LTC2992 register addresses touched by the power-up table
  localparam logic [7:0] REG_CTRLA  = 8'h00;
  localparam logic [7:0] REG_CTRLB  = 8'h01;
  localparam logic [7:0] REG_ALERT1 = 8'h02;
  localparam logic [7:0] REG_NADC   = 8'h04;

  // Default write table, {register, data} per entry
  localparam logic [15:0] CFG_DEFAULT [4] = '{
    {REG_CTRLA,  8'h00},
    {REG_CTRLB,  8'h00},
    {REG_NADC,   8'h00},
    {REG_ALERT1, 8'h00}
  };

endpackage

// File: rtl/ltc2992_cfg_seq_if.sv
// Sequencer <-> controller/IIC_send signal bundle.
interface ltc2992_cfg_seq_if;
  logic       I_start;
  logic       I_iic_done;
  logic       O_send_en;
  logic [6:0] O_dev_addr;
  logic [7:0] O_word_addr;
  logic [7:0] O_write_data;
  logic       O_busy;
  logic       O_done;
  logic       O_err;
  logic [3:0] O_err_idx;

  modport master (
    input  I_start, I_iic_done,
    output O_send_en, O_dev_addr, O_word_addr, O_write_data,
           O_busy, O_done, O_err, O_err_idx
  );

  modport slave (
    output I_start, I_iic_done,
    input  O_send_en, O_dev_addr, O_word_addr, O_write_data,
           O_busy, O_done, O_err, O_err_idx
  );
endinterface

// File: rtl/ltc2992_cfg_rom.sv
// Combinational lookup of the configuration table: idx -> {addr, data}.
module ltc2992_cfg_rom
  import ltc2992_cfg_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic [3:0]  idx_i,
  output logic [15:0] entry_o
);

  // Entries past the active table length (or past the defaults) read as zero
  always_comb begin
    entry_o = '0;
    if (({28'd0, idx_i} < NUM_REGS) && (idx_i[3:2] == 2'b00)) begin
      entry_o = CFG_DEFAULT[idx_i[1:0]];
    end
  end

endmodule

// File: rtl/ltc2992_cfg_seq.sv
// LTC2992 configuration sequencer: walks the write table through IIC_send,
// with per-write timeout and bounded retry.
module ltc2992_cfg_seq
  import ltc2992_cfg_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h6F,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned RETRY_MAX   = 3,
  parameter int unsigned GAP_CYC     = 4
) (
  input logic                I_clk,
  input logic                I_rst,
  ltc2992_cfg_seq_if.master  bus
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [TW-1:0] TMR_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(NUM_REGS - 1);
  localparam logic [2:0]    RETRY_LAST = 3'(RETRY_MAX - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ok_q, ok_d;
  logic          send_en_q, send_en_d;
  logic [7:0]    word_q, word_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [3:0]    err_idx_q, err_idx_d;
  logic [15:0]   rom_entry;

  ltc2992_cfg_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .idx_i   (idx_d),
    .entry_o (rom_entry)
  );

  // State register and all datapath registers
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      ok_q      <= 1'b0;
      send_en_q <= 1'b0;
      word_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      ok_q      <= ok_d;
      send_en_q <= send_en_d;
      word_q    <= word_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Next-state, counters and registered outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    ok_d      = ok_q;
    send_en_d = send_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.I_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          retry_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        timer_d   = '0;
        send_en_d = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (timer_q != '1) timer_d = timer_q + TW'(1);
        if (bus.I_iic_done) begin
          send_en_d = 1'b0;
          ok_d      = 1'b1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else if (timer_q == TMR_LAST) begin
          send_en_d = 1'b0;
          ok_d      = 1'b0;
          if (retry_q == RETRY_LAST) begin
            state_d = ST_ERR;
          end else begin
            retry_d = retry_q + 3'd1;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (ok_q && (idx_q == IDX_LAST)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (ok_q) begin
            idx_d   = idx_q + 4'd1;
            retry_d = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data are captured on entry to LOAD (from the upcoming idx) so they
  // are already settled for the whole LOAD cycle before send enable rises.
  always_comb begin
    word_d = word_q;
    data_d = data_q;
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      word_d = rom_entry[15:8];
      data_d = rom_entry[7:0];
    end
  end

  assign bus.O_send_en    = send_en_q;
  assign bus.O_dev_addr   = DEV_ADDR;
  assign bus.O_word_addr  = word_q;
  assign bus.O_write_data = data_q;
  assign bus.O_busy       = busy_q;
  assign bus.O_done       = done_q;
  assign bus.O_err        = err_q;
  assign bus.O_err_idx    = err_idx_q;

endmodule

// File: tb/tb_ltc2992_cfg_seq.sv
// Randomized bench for ltc2992_cfg_seq against a per-attempt reference model.
module tb_ltc2992_cfg_seq;

  localparam int TO = 1000;
  localparam int G  = 4;
  localparam int RM = 3;
  localparam int NR = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         len;
    bit         stable;
    bit         pre_ok;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ltc2992_cfg_seq_if bus ();

  ltc2992_cfg_seq #(
    .DEV_ADDR    (7'h6F),
    .NUM_REGS    (NR),
    .TIMEOUT_CYC (TO),
    .RETRY_MAX   (RM),
    .GAP_CYC     (G)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Attempt plan: 0 = slave silent, N = done on the N-th enable-high cycle
  int   plan[$];
  win_t act_q[$];
  win_t exp_q[$];
  int   busy_cnt = 0;
  int   done_cnt = 0;
  bit   spur = 0;

  logic [7:0] exp_addr [4];

  // responder state
  bit r_in  = 0;
  int r_cnt = 0;
  int r_cur = 0;
  // monitor state
  bit         m_in = 0;
  win_t       m_w;
  logic [7:0] m_pa = '0;
  logic [7:0] m_pd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // IIC_send stand-in: raises done according to the plan
  initial begin
    forever begin
      @(negedge clk);
      if (bus.O_send_en === 1'b1) begin
        if (!r_in) begin
          r_in  = 1;
          r_cnt = 0;
          r_cur = (plan.size() > 0) ? plan.pop_front() : 0;
        end
        r_cnt++;
        bus.I_iic_done = (r_cur != 0) && (r_cnt == r_cur);
      end else begin
        r_in = 0;
        bus.I_iic_done = spur && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Records each enable window plus busy/done activity
  initial begin
    forever begin
      @(negedge clk);
      if (bus.O_send_en === 1'b1) begin
        if (!m_in) begin
          m_in       = 1;
          m_w.a      = bus.O_word_addr;
          m_w.d      = bus.O_write_data;
          m_w.len    = 0;
          m_w.stable = 1;
          m_w.pre_ok = (m_pa === bus.O_word_addr) && (m_pd === bus.O_write_data);
        end
        m_w.len++;
        if (bus.O_word_addr !== m_w.a || bus.O_write_data !== m_w.d) m_w.stable = 0;
      end else if (m_in) begin
        m_in = 0;
        act_q.push_back(m_w);
      end
      if (bus.O_busy === 1'b1) busy_cnt++;
      if (bus.O_done === 1'b1) done_cnt++;
      m_pa = bus.O_word_addr;
      m_pd = bus.O_write_data;
    end
  end

  // Expected windows and outcome, derived from the plan entry by entry
  task automatic build_model(output bit m_err, output int m_eidx, output int m_busy);
    int   k;
    int   b;
    bit   ok;
    win_t w;
    k = 0;
    m_err = 0;
    m_eidx = 0;
    m_busy = 1;
    exp_q.delete();
    for (int e = 0; e < NR && !m_err; e++) begin
      ok = 0;
      for (int r = 0; r < RM && !ok; r++) begin
        b = (k < plan.size()) ? plan[k] : 0;
        k++;
        w.a = exp_addr[e];
        w.d = 8'h00;
        w.len = (b == 0) ? TO : b;
        w.stable = 1;
        w.pre_ok = 1;
        exp_q.push_back(w);
        ok = (b != 0);
        m_busy += 1 + w.len + G;
      end
      if (!ok) begin
        m_err = 1;
        m_eidx = e;
      end
    end
  endtask

  task automatic run(input string name, input bit spam);
    bit m_err;
    int m_eidx;
    int m_busy;
    int n;
    int lim;
    build_model(m_err, m_eidx, m_busy);
    act_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    bus.I_start = 1'b1;
    @(negedge clk);
    bus.I_start = 1'b0;
    check({name, "_busy_on"}, 32'(bus.O_busy), 32'd1);
    check({name, "_err_clr"}, 32'(bus.O_err), 32'd0);
    n = 0;
    while (bus.O_busy === 1'b1 && n < 20000) begin
      if (spam) bus.I_start = (bus.O_done === 1'b1) ? 1'b1 : ($urandom_range(0, 5) == 0);
      @(negedge clk);
      n++;
    end
    bus.I_start = 1'b0;
    check({name, "_finished"}, 32'(n < 20000), 32'd1);
    repeat (6) @(negedge clk);
    check({name, "_idle_after"}, 32'(bus.O_busy), 32'd0);
    check({name, "_nwin"}, 32'(act_q.size()), 32'(exp_q.size()));
    lim = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      check($sformatf("%s_w%0d_addr", name, i), 32'(act_q[i].a), 32'(exp_q[i].a));
      check($sformatf("%s_w%0d_data", name, i), 32'(act_q[i].d), 32'(exp_q[i].d));
      check($sformatf("%s_w%0d_len", name, i), 32'(act_q[i].len), 32'(exp_q[i].len));
      check($sformatf("%s_w%0d_stable", name, i), 32'(act_q[i].stable), 32'd1);
      check($sformatf("%s_w%0d_presetup", name, i), 32'(act_q[i].pre_ok), 32'd1);
    end
    check({name, "_done_cnt"}, 32'(done_cnt), m_err ? 32'd0 : 32'd1);
    check({name, "_err"}, 32'(bus.O_err), 32'(m_err));
    if (m_err) check({name, "_err_idx"}, 32'(bus.O_err_idx), 32'(m_eidx));
    else       check({name, "_latency"}, 32'(busy_cnt), 32'(m_busy));
  endtask

  task automatic random_plan();
    int r;
    plan.delete();
    for (int i = 0; i < NR * RM; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      plan.push_back(0);
      else if (r < 20) plan.push_back(TO);
      else             plan.push_back($urandom_range(1, 60));
    end
  endtask

  initial begin
    exp_addr[0] = 8'h00;
    exp_addr[1] = 8'h01;
    exp_addr[2] = 8'h04;
    exp_addr[3] = 8'h02;
    rst = 1'b1;
    bus.I_start = 1'b0;
    bus.I_iic_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send_en", 32'(bus.O_send_en), 32'd0);
    check("rst_busy", 32'(bus.O_busy), 32'd0);
    check("rst_done", 32'(bus.O_done), 32'd0);
    check("rst_err", 32'(bus.O_err), 32'd0);
    check("rst_err_idx", 32'(bus.O_err_idx), 32'd0);
    check("rst_word", 32'(bus.O_word_addr), 32'd0);
    check("rst_data", 32'(bus.O_write_data), 32'd0);
    check("dev_addr", 32'(bus.O_dev_addr), 32'h6F);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all writes acknowledged after 300 cycles
    plan = '{300, 300, 300, 300};
    run("t1", 0);

    // entry 1 silent once, then acknowledged
    plan = '{5, 0, 7, 9, 11};
    run("t2", 0);

    // entry 2 never acknowledged
    plan = '{5, 6, 0, 0, 0};
    run("t3", 0);
    check("t3_err_sticky", 32'(bus.O_err), 32'd1);

    // done on the last allowed cycle counts as success; retry restarts per entry
    plan = '{0, 0, TO, 0, 0, 5, 6, 7};
    run("t4", 0);

    // asynchronous reset in the middle of entry 0
    plan = '{0};
    bus.I_start = 1'b1;
    @(negedge clk);
    bus.I_start = 1'b0;
    repeat (50) @(negedge clk);
    check("t5_pre_send_en", 32'(bus.O_send_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_send_en", 32'(bus.O_send_en), 32'd0);
    check("t5_rst_busy", 32'(bus.O_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    plan = '{20, 21, 22, 23};
    run("t5", 0);

    // start pulses while busy and on the done cycle are ignored
    spur = 1;
    plan = '{9, 0, 12, 15, 30};
    run("t6", 1);

    for (int k = 0; k < 6; k++) begin
      random_plan();
      run($sformatf("rnd%0d", k), (k % 2) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
